// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the bit-serial adder/subtractor.
//   state_t : FSM encoding (IDLE/RUN/DONE)
//   OP_ADD / OP_SUB : encoding of the sub input
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/gp_cell.sv
// Single-bit generate/propagate cell.
//   a, b : operand bits
//   g    : generate  (a & b)
//   p    : propagate (a ^ b)
module gp_cell (
  input  logic a,
  input  logic b,
  output logic g,
  output logic p
);

  assign g = a & b;
  assign p = a ^ b;

endmodule

// File: rtl/serial_addsub_gp.sv
// Bit-serial WIDTH-bit adder/subtractor, one bit per clock, LSB first.
// A single G/P cell plus a carry flop implements C' = G | (P & C), S = P ^ C.
//   clk, rst   : clock, async active-high reset
//   start, sub : launch request and op select (0 add, 1 subtract)
//   a, b       : operands, sampled when start is accepted
//   busy       : operation in progress
//   done       : one-cycle pulse, result/cout/overflow valid
//   result     : sum/difference, held until the next operation completes
//   cout       : carry out of MSB (subtract: 1 = no borrow)
//   overflow   : signed overflow (carry into MSB ^ carry out of MSB)
module serial_addsub_gp
  import arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, acc;
  logic [CW-1:0]    cnt;
  logic             carry, c_msb_in;
  logic             g, p, s, c_nxt;
  logic             accept, last_bit;

  gp_cell u_gp (
    .a (a_sr[0]),
    .b (b_sr[0]),
    .g (g),
    .p (p)
  );

  assign s        = p ^ carry;
  assign c_nxt    = g | (p & carry);
  assign last_bit = (cnt == CW'(WIDTH-1));
  // DONE accepts start like IDLE so operations can run back to back.
  assign accept   = start && (state == IDLE || state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr     <= '0;
      b_sr     <= '0;
      acc      <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
      a_sr  <= a;
      b_sr  <= (sub == OP_ADD) ? b : ~b;
      carry <= sub;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      acc   <= {s, acc[WIDTH-1:1]};
      carry <= c_nxt;
      cnt   <= cnt + 1'b1;
      if (cnt == CW'(WIDTH-2)) c_msb_in <= c_nxt;
      // Outputs are only touched here so they stay stable between completions.
      if (last_bit) begin
        result   <= {s, acc[WIDTH-1:1]};
        cout     <= c_nxt;
        overflow <= c_msb_in ^ c_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub_gp.sv
module tb_serial_addsub_gp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, cout, overflow;
  logic [7:0] result;

  int n_chk  = 0;
  int n_pass = 0;

  serial_addsub_gp #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, wait for done; returns edges after acceptance and busy cycles.
  task automatic run_op(input logic s, input logic [7:0] av, input logic [7:0] bv,
                        input logic hold, output int edges, output int nbusy);
    sub = s; a = av; b = bv; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    edges = 0; nbusy = 0;
    for (int k = 1; k <= 20; k++) begin
      if (busy) nbusy++;
      tick();
      if (done) begin edges = k; break; end
    end
    if (edges == 0) chk("timeout", 0, 1);
  endtask

  task automatic chk_res(input string tag, input logic [7:0] r, input logic c, input logic v);
    chk({tag, " result"}, result, r);
    chk({tag, " cout"}, cout, c);
    chk({tag, " ovf"}, overflow, v);
  endtask

  int e, nb, ndone;

  initial begin
    #12;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst result", result, 0);
    chk("rst cout", cout, 0);
    chk("rst ovf", overflow, 0);
    rst = 1'b0;
    tick();

    // Basic add with latency and busy length
    run_op(1'b0, 8'h3C, 8'h42, 1'b0, e, nb);
    chk("add1 edges", e, 8);
    chk("add1 busy cycles", nb, 8);
    chk("add1 busy in done", busy, 0);
    chk_res("add1", 8'h7E, 1'b0, 1'b0);
    tick();
    chk("add1 done pulse", done, 0);

    run_op(1'b0, 8'hFF, 8'h01, 1'b0, e, nb);
    chk_res("add ff+1", 8'h00, 1'b1, 1'b0);
    run_op(1'b0, 8'h7F, 8'h01, 1'b0, e, nb);
    chk_res("add 7f+1", 8'h80, 1'b0, 1'b1);
    run_op(1'b1, 8'h05, 8'h07, 1'b0, e, nb);
    chk_res("sub 5-7", 8'hFE, 1'b0, 1'b0);
    run_op(1'b1, 8'h80, 8'h01, 1'b0, e, nb);
    chk_res("sub 80-1", 8'h7F, 1'b1, 1'b1);
    tick();

    // Back to back: start held high, new operands presented in DONE cycle
    run_op(1'b0, 8'h3C, 8'h42, 1'b1, e, nb);
    chk_res("b2b first", 8'h7E, 1'b0, 1'b0);
    sub = 1'b1; a = 8'h10; b = 8'h10;
    tick();
    chk("b2b no gap", busy, 1);
    sub = 1'b0; a = 8'hA5; b = 8'h33;  // ignored during RUN
    start = 1'b0;
    e = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin e = k; break; end
    end
    chk("b2b edges", e, 8);
    chk_res("b2b second", 8'h00, 1'b1, 1'b0);
    tick();

    // Start pulse mid-RUN is ignored
    sub = 1'b0; a = 8'h05; b = 8'h03; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; e = 0;
    for (int k = 1; k <= 15; k++) begin
      if (k == 3) begin start = 1'b1; sub = 1'b1; a = 8'hAA; b = 8'h55; end
      if (k == 4) start = 1'b0;
      tick();
      if (done) begin ndone++; if (e == 0) e = k; end
    end
    chk("midrun done count", ndone, 1);
    chk("midrun edges", e, 8);
    chk_res("midrun", 8'h08, 1'b0, 1'b0);

    // Async reset in the middle of an operation
    sub = 1'b0; a = 8'h7F; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    chk("arst result", result, 0);
    chk("arst cout", cout, 0);
    chk("arst ovf", overflow, 0);
    #3 rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("arst no activity", ndone, 0);
    run_op(1'b0, 8'h01, 8'h01, 1'b0, e, nb);
    chk("post rst edges", e, 8);
    chk_res("post rst", 8'h02, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
